// File: rtl/bdd_sbox_rx_if.sv
// Request/response and dual-rail signal bundle between the S-box receiver
// controller and its environment (requester, S-box rails and result consumer).
interface bdd_sbox_rx_if;
  logic       start;
  logic [3:0] din;
  logic       pre;
  logic [3:0] sel;
  logic [3:0] selBar;
  logic [3:0] u_rail;
  logic [3:0] c_rail;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  modport slave (
    input  start, din, u_rail, c_rail, dout_ready,
    output pre, sel, selBar, dout, dout_valid, busy, err, err_code
  );

  modport master (
    output start, din, u_rail, c_rail, dout_ready,
    input  pre, sel, selBar, dout, dout_valid, busy, err, err_code
  );
endinterface

// File: rtl/bdd_sbox_rx.sv
// Controller for a precharged dual-rail (BDD) S-box: drives the select rails,
// checks the null spacer, detects completion on stable rails and holds the result.
module bdd_sbox_rx #(
  parameter int PRE_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  bdd_sbox_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    EVAL,
    HOLD,
    ERR
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_NULL = 2'd1;
  localparam logic [1:0] CODE_PAIR = 2'd2;
  localparam logic [1:0] CODE_TMO  = 2'd3;

  localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [3:0] din_q, din_q_next;
  logic [3:0] pre_cnt_reg, pre_cnt_next;
  logic [7:0] tmo_cnt_reg, tmo_cnt_next;
  logic [3:0] dout_reg, dout_next;
  logic       err_reg, err_next;
  logic [1:0] err_code_reg, err_code_next;

  // Rail samples: [7:4] = u rails, [3:0] = c rails.
  logic [7:0] rail_q, rail_qq;

  logic [3:0] bit_both;
  logic [3:0] bit_one;
  logic       any_both;
  logic       all_one;
  logic       rails_null;
  logic       rails_stable;
  logic       drive_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rail
      assign bit_both[gi] = rail_q[4 + gi] & rail_q[gi];
      assign bit_one[gi]  = rail_q[4 + gi] ^ rail_q[gi];
    end
  endgenerate

  assign any_both     = |bit_both;
  assign all_one      = &bit_one;
  assign rails_null   = (rail_q == 8'h00);
  assign rails_stable = (rail_q == rail_qq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      din_q        <= 4'h0;
      pre_cnt_reg  <= 4'h0;
      tmo_cnt_reg  <= 8'h00;
      dout_reg     <= 4'h0;
      err_reg      <= 1'b0;
      err_code_reg <= CODE_NONE;
      rail_q       <= 8'h00;
      rail_qq      <= 8'h00;
    end else begin
      state_reg    <= state_next;
      din_q        <= din_q_next;
      pre_cnt_reg  <= pre_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      dout_reg     <= dout_next;
      err_reg      <= err_next;
      err_code_reg <= err_code_next;
      rail_q       <= {bus.u_rail, bus.c_rail};
      rail_qq      <= rail_q;
    end
  end

  always_comb begin
    state_next    = state_reg;
    din_q_next    = din_q;
    pre_cnt_next  = pre_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    dout_next     = dout_reg;
    err_next      = err_reg;
    err_code_next = err_code_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          din_q_next    = bus.din;
          err_next      = 1'b0;
          err_code_next = CODE_NONE;
          pre_cnt_next  = PRE_LOAD;
          state_next    = PRECHARGE;
        end
      end
      PRECHARGE: begin
        if (pre_cnt_reg == 4'h0) begin
          if (rails_null) begin
            tmo_cnt_next = 8'h00;
            state_next   = EVAL;
          end else begin
            err_next      = 1'b1;
            err_code_next = CODE_NULL;
            state_next    = ERR;
          end
        end else begin
          pre_cnt_next = pre_cnt_reg - 4'h1;
        end
      end
      EVAL: begin
        // An illegal pair outranks both completion and timeout.
        if (any_both) begin
          err_next      = 1'b1;
          err_code_next = CODE_PAIR;
          state_next    = ERR;
        end else if (all_one && rails_stable) begin
          dout_next  = rail_q[7:4];
          state_next = HOLD;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          err_next      = 1'b1;
          err_code_next = CODE_TMO;
          state_next    = ERR;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 8'h01;
        end
      end
      HOLD: begin
        if (bus.dout_ready) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Selects stay driven through HOLD so the rails keep the captured codeword.
  assign drive_sel = (state_reg == EVAL) || (state_reg == HOLD);

  assign bus.pre        = drive_sel;
  assign bus.sel        = drive_sel ? din_q : 4'h0;
  assign bus.selBar     = drive_sel ? ~din_q : 4'h0;
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = (state_reg == HOLD);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.err        = err_reg;
  assign bus.err_code   = err_code_reg;

endmodule

// File: tb/tb_bdd_sbox_rx.sv
// Bench for bdd_sbox_rx: an S-box rail environment, a transaction-level reference
// model compared every cycle, directed corner cases and randomized transactions.
module tb_bdd_sbox_rx;

  localparam int P = 2;
  localparam int T = 15;

  localparam int S_IDLE = 0;
  localparam int S_PRE  = 1;
  localparam int S_EVAL = 2;
  localparam int S_HOLD = 3;
  localparam int S_ERR  = 4;

  localparam int M_VAL    = 0;
  localparam int M_NULL   = 1;
  localparam int M_NEVER  = 2;
  localparam int M_GLITCH = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bdd_sbox_rx_if bus();

  bdd_sbox_rx #(.PRE_CYCLES(P), .TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_phase = S_IDLE;
  int         m_age   = 0;
  int         m_k     = 0;
  logic [3:0] m_din   = 4'h0;
  logic [3:0] m_dout  = 4'h0;
  logic       m_err   = 1'b0;
  logic [1:0] m_code  = 2'd0;
  logic [7:0] seen[$];

  // Rails present n cycles before the current one ({u,c}); nothing seen means null.
  function automatic logic [7:0] rail_ago(input int n);
    int idx;
    idx = seen.size() - 1 - n;
    return (idx >= 0) ? seen[idx] : 8'h00;
  endfunction

  function automatic bit has_both(input logic [7:0] r);
    return |(r[7:4] & r[3:0]);
  endfunction

  function automatic bit codeword(input logic [7:0] r);
    return (r[7:4] ^ r[3:0]) == 4'hF;
  endfunction

  function automatic logic [3:0] upper(input logic [7:0] r);
    return r[7:4];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= S_IDLE;
      m_age   <= 0;
      m_k     <= 0;
      m_din   <= 4'h0;
      m_dout  <= 4'h0;
      m_err   <= 1'b0;
      m_code  <= 2'd0;
      seen.delete();
    end else begin
      case (m_phase)
        S_IDLE: if (bus.start) begin
          m_phase <= S_PRE;
          m_age   <= 1;
          m_din   <= bus.din;
          m_err   <= 1'b0;
          m_code  <= 2'd0;
        end
        S_PRE: begin
          if (m_age < P) m_age <= m_age + 1;
          else if (rail_ago(1) == 8'h00) begin
            m_phase <= S_EVAL;
            m_k     <= 1;
          end else begin
            m_phase <= S_ERR;
            m_err   <= 1'b1;
            m_code  <= 2'd1;
          end
        end
        S_EVAL: begin
          if (has_both(rail_ago(1))) begin
            m_phase <= S_ERR;
            m_err   <= 1'b1;
            m_code  <= 2'd2;
          end else if (codeword(rail_ago(1)) && rail_ago(1) == rail_ago(2)) begin
            m_phase <= S_HOLD;
            m_dout  <= upper(rail_ago(1));
          end else if (m_k == T) begin
            m_phase <= S_ERR;
            m_err   <= 1'b1;
            m_code  <= 2'd3;
          end else begin
            m_k <= m_k + 1;
          end
        end
        S_HOLD: if (bus.dout_ready) m_phase <= S_IDLE;
        default: m_phase <= S_IDLE;
      endcase
    end
  end

  function automatic logic [17:0] act_vec();
    return {bus.pre, bus.sel, bus.selBar, bus.dout, bus.dout_valid, bus.busy, bus.err, bus.err_code};
  endfunction

  function automatic logic [17:0] exp_vec();
    logic on;
    on = (m_phase == S_EVAL) || (m_phase == S_HOLD);
    return {on, on ? m_din : 4'h0, on ? ~m_din : 4'h0, m_dout,
            m_phase == S_HOLD, m_phase != S_IDLE, m_err, m_code};
  endfunction

  always @(negedge clk) begin
    check("cycle", {14'h0, act_vec()}, {14'h0, exp_vec()});
  end

  // ---------------- S-box rail environment ----------------
  int         tx_mode  = M_VAL;
  int         tx_delay = 0;
  logic [3:0] tx_u     = 4'h0;
  logic [3:0] tx_c     = 4'h0;

  always @(negedge clk) begin
    logic [7:0] r;
    r = 8'h00;
    if (m_phase == S_PRE && tx_mode == M_NULL) begin
      r = 8'h80;
    end else if ((m_phase == S_EVAL && m_k > tx_delay) || m_phase == S_HOLD) begin
      case (tx_mode)
        M_VAL:    r = {tx_u, tx_c};
        M_GLITCH: r = (m_phase == S_EVAL && m_k == tx_delay + 1) ?
                      {tx_u ^ 4'h1, ~(tx_u ^ 4'h1)} : {tx_u, tx_c};
        default:  r = 8'h00;
      endcase
    end
    bus.u_rail = r[7:4];
    bus.c_rail = r[3:0];
    if (rst_n) seen.push_back(r);
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  // ---------------- transaction driver ----------------
  int         tx_lat, tx_pre_n, tx_dv_n;
  logic [3:0] tx_sel, tx_selb, tx_err_vec;
  logic       tx_err0;

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_phase != S_IDLE && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_tx(input string tag, input int mode, input logic [3:0] d,
                       input logic [3:0] u, input logic [3:0] c, input int dly,
                       input int hold_wait);
    int n, hold_n;
    wait_idle();
    tx_mode = mode; tx_u = u; tx_c = c; tx_delay = dly;
    bus.start = 1'b1;
    bus.din   = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = 4'($urandom);
    tx_lat = -1; tx_pre_n = 0; tx_dv_n = 0; tx_sel = 4'h0; tx_selb = 4'h0;
    tx_err_vec = 4'hF; tx_err0 = bus.err;
    n = 0; hold_n = 0;
    while (m_phase != S_IDLE && n < 300) begin
      if (bus.pre) begin
        if (tx_pre_n == 0) begin
          tx_sel  = bus.sel;
          tx_selb = bus.selBar;
        end
        tx_pre_n++;
      end
      if (bus.dout_valid) begin
        if (tx_lat < 0) tx_lat = n;
        tx_dv_n++;
      end
      if (m_phase == S_ERR) tx_err_vec = {bus.pre, bus.err, bus.err_code};
      if (m_phase == S_HOLD) begin
        hold_n++;
        bus.dout_ready = (hold_wait < 0) ? 1'($urandom_range(0, 1)) : (hold_n > hold_wait);
      end else begin
        bus.dout_ready = 1'($urandom_range(0, 1));
      end
      bus.start = ($urandom_range(0, 3) == 0) || (hold_n == 3);
      bus.din   = 4'($urandom);
      @(negedge clk);
      n++;
    end
    bus.start      = 1'b0;
    bus.dout_ready = 1'b0;
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL tx_%s_done: still busy after %0d cycles, required idle", tag, n);
    end
    $display("tx %s din=%h u=%h c=%h mode=%0d -> dout=%h err=%0b code=%0d lat=%0d eval_cycles=%0d",
             tag, d, u, c, mode, bus.dout, bus.err, bus.err_code, tx_lat, tx_pre_n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.start = 1'b0; bus.din = 4'h0; bus.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {14'h0, act_vec()}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Nominal, backpressure and first-edge acceptance after reset.
    do_tx("nominal", M_VAL, 4'hA, 4'h3, 4'hC, 0, 5);
    check("nom_sel", 32'(tx_sel), 32'hA);
    check("nom_selbar", 32'(tx_selb), 32'h5);
    check("nom_latency", tx_lat, P + 3);
    check("nom_hold_cycles", tx_dv_n, 6);
    check("nom_dout", 32'(bus.dout), 32'h3);
    check("nom_valid_after", 32'(bus.dout_valid), 0);
    check("nom_err", 32'(bus.err), 0);
    check("nom_model_dout", 32'(m_dout), 32'h3);

    do_tx("illegal", M_VAL, 4'h6, 4'h1, 4'hF, 0, 0);
    check("ill_err_cycle", 32'(tx_err_vec), 32'h6);
    check("ill_eval_cycles", tx_pre_n, 2);
    check("ill_err_sticky", 32'({bus.err, bus.err_code}), 32'h6);

    do_tx("null_fail", M_NULL, 4'h5, 4'h8, 4'h0, 0, 0);
    check("null_err_cleared", 32'(tx_err0), 0);
    check("null_err_cycle", 32'(tx_err_vec), 32'h5);
    check("null_no_eval", tx_pre_n, 0);

    do_tx("timeout", M_NEVER, 4'h2, 4'h0, 4'h0, 0, 0);
    check("tmo_code", 32'(bus.err_code), 3);
    check("tmo_eval_cycles", tx_pre_n, T);

    do_tx("glitch", M_GLITCH, 4'h9, 4'hE, 4'h1, 1, 0);
    check("glitch_latency", tx_lat, 7);
    check("glitch_dout", 32'(bus.dout), 32'hE);

    // Asynchronous reset in the second EVAL cycle.
    wait_idle();
    tx_mode = M_VAL; tx_u = 4'h4; tx_c = 4'hB; tx_delay = 0;
    bus.start = 1'b1; bus.din = 4'hC;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(m_phase == S_EVAL && m_k == 2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_pre", 32'(bus.pre), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", {14'h0, act_vec()}, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    do_tx("after_reset", M_VAL, 4'h3, 4'hB, 4'h4, 0, 0);
    check("after_reset_dout", 32'(bus.dout), 32'hB);
    check("after_reset_err", 32'(bus.err), 0);

    for (int i = 0; i < 60; i++) begin
      int         pick, mode, dly;
      logic [3:0] d, u, c;
      d = 4'($urandom);
      u = sbox(d);
      c = ~u;
      dly = $urandom_range(0, 3);
      pick = $urandom_range(0, 19);
      if (pick < 11) mode = M_VAL;
      else if (pick < 14) begin
        mode = M_VAL;
        c = 4'($urandom);
      end
      else if (pick < 16) mode = M_NULL;
      else if (pick < 17) mode = M_NEVER;
      else mode = M_GLITCH;
      do_tx("random", mode, d, u, c, dly, -1);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/bdd_sbox_rx.md
BDD_SBOX_RX -- requirements
Module: bdd_sbox_rx

Interface
REQ-001 Parameter PRE_CYCLES, default 2: number of precharge cycles per evaluation (legal range 1..15).
REQ-002 Parameter TIMEOUT, default 15: maximum number of EVAL cycles before an error (legal range 2..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request one S-box evaluation of din.
REQ-006 din  input  4  S-box input nibble.
REQ-007 pre  output  1  dual-rail precharge control; 0 = precharge (rails forced to null), 1 = evaluate.
REQ-008 sel  output  4  true select line per S-box input bit.
REQ-009 selBar  output  4  complement select line per S-box input bit.
REQ-010 u_rail  input  4  uncomplemented output rails from the S-box.
REQ-011 c_rail  input  4  complemented output rails from the S-box.
REQ-012 dout  output  4  captured S-box result (u_rail value).
REQ-013 dout_valid  output  1  dout holds a result.
REQ-014 dout_ready  input  1  consumer accepts dout.
REQ-015 busy  output  1  1 whenever the state is not IDLE.
REQ-016 err  output  1  sticky error flag.
REQ-017 err_code  output  2  error cause: 0 none, 1 null-spacer failure, 2 illegal rail pair (both rails 1), 3 timeout.

Function
REQ-018 The block SHALL implement the FSM states IDLE, PRECHARGE, EVAL, HOLD and ERR.
REQ-019 The block SHALL register u_rail/c_rail every cycle into rail_q and keep the previous sample in rail_qq; all rail decisions SHALL use rail_q and rail_qq only.
REQ-020 In IDLE, PRECHARGE and ERR, the outputs SHALL be pre=0, sel=0 and selBar=0; sel and selBar SHALL never both be 1 on the same bit in any state.
REQ-021 IDLE: when start=1, the block SHALL latch din into din_q, clear err and err_code, load the cycle counter, and enter PRECHARGE on the next edge.
REQ-022 PRECHARGE: the block SHALL stay for exactly PRE_CYCLES cycles.
REQ-023 PRECHARGE exit: if all 8 bits of rail_q are 0, the block SHALL enter EVAL; otherwise it SHALL enter ERR with err_code=1.
REQ-024 EVAL: the outputs SHALL be pre=1, sel=din_q and selBar=~din_q.
REQ-025 EVAL: the block SHALL clear the timeout counter on entry and increment it once per EVAL cycle.
REQ-026 EVAL completion: when every bit of rail_q has exactly one rail at 1 and rail_q equals rail_qq, the block SHALL capture dout=rail_q.u and enter HOLD.
REQ-027 EVAL illegal pair: when any bit of rail_q has both rails at 1, the block SHALL enter ERR with err_code=2; this check SHALL take priority over completion.
REQ-028 EVAL timeout: when the timeout counter reaches TIMEOUT without completion, the block SHALL enter ERR with err_code=3; an illegal pair detected in the same cycle SHALL take priority (err_code=2).
REQ-029 HOLD: the outputs SHALL be pre=1 (rails kept stable), dout_valid=1, and dout held constant.
REQ-030 HOLD: the block SHALL return to IDLE on the edge where dout_valid=1 and dout_ready=1, with dout_valid=0 from the following cycle.
REQ-031 HOLD: dout SHALL retain its value in IDLE until the next capture.
REQ-032 ERR: the block SHALL stay exactly one cycle and then return to IDLE; err=1 and err_code SHALL persist until the next accepted start.
REQ-033 start asserted while busy=1 SHALL be ignored, including start in the same cycle as a HOLD handshake.
REQ-034 Best-case latency SHALL be: start accepted at cycle 0, PRECHARGE cycles 1..PRE_CYCLES, completion decided no earlier than 2 EVAL cycles after rails settle, and dout_valid=1 the cycle after completion.
REQ-035 din changes after acceptance SHALL have no effect on sel/selBar.

Reset
REQ-036 While rst_n=0, the block SHALL immediately force: state IDLE, pre=0, sel=0, selBar=0, dout=0, dout_valid=0, busy=0, err=0, err_code=0, and all counters and rail samples cleared.
REQ-037 A reset asserted mid-EVAL or mid-HOLD SHALL drop pre and dout_valid asynchronously, with no partial capture.
REQ-038 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-039 Nominal case: PRE_CYCLES=2, start with din=4'hA, rails null in precharge, u=4'h3/c=4'hC from EVAL cycle 1 -> sel=4'hA, selBar=4'h5, dout=4'h3, dout_valid=1, err=0.
REQ-040 Backpressure: dout_ready=0 for 5 cycles in HOLD, plus a start pulse in that window -> dout stable, pre=1, start ignored; dout_ready=1 -> IDLE on the next edge.
REQ-041 Illegal pair: u=4'h1, c=4'hF during EVAL -> ERR with err=1, err_code=2, pre=0 in the next cycle; the next start clears err.
REQ-042 Null failure: u_rail=4'h8 during PRECHARGE -> err_code=1 and EVAL never entered (pre stays 0).
REQ-043 Timeout: rails remain all-zero during EVAL, TIMEOUT=15 -> err_code=3 after 15 EVAL cycles.
REQ-044 Reset mid-operation: rst_n=0 in EVAL cycle 2 -> all outputs return to reset values without waiting for a clock edge; a start after release completes normally.
